// File: rtl/game_telemetry_tx_if.sv
// Gameplay-to-telemetry bundle: snapshot inputs, frame tick and the UART/status outputs.
// The slave modport is the transmitter; the master modport is the gameplay/board side.
interface game_telemetry_tx_if;
   logic        enable_in;
   logic        new_frame;
   logic [15:0] ball_position_x;
   logic [15:0] ball_position_y;
   logic [15:0] ball_speed;
   logic [15:0] ball_direction;
   logic [15:0] cam_angle;
   logic [7:0]  score;
   logic [2:0]  state_in;
   logic        tx_out;
   logic        busy_out;
   logic        packet_done;
   logic [7:0]  dropped_count;

   modport master (
      output enable_in, new_frame, ball_position_x, ball_position_y, ball_speed,
             ball_direction, cam_angle, score, state_in,
      input  tx_out, busy_out, packet_done, dropped_count
   );

   modport slave (
      input  enable_in, new_frame, ball_position_x, ball_position_y, ball_speed,
             ball_direction, cam_angle, score, state_in,
      output tx_out, busy_out, packet_done, dropped_count
   );
endinterface

// File: rtl/game_telemetry_tx.sv
// Frame-synchronous 8N1 UART transmitter for gameplay state snapshots.
// Define TELEMETRY_CHECKSUM_EN to append an XOR checksum byte (14-byte packets instead of 13).
module game_telemetry_tx #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned FRAME_DIVIDE = 1,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic               clk_in,
   input  logic               rst_in_n,
   game_telemetry_tx_if.slave tel
);

`ifdef TELEMETRY_CHECKSUM_EN
   localparam int unsigned NUM_BYTES = 14;
`else
   localparam int unsigned NUM_BYTES = 13;
`endif

   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned DIV_W  = (FRAME_DIVIDE > 1) ? $clog2(FRAME_DIVIDE) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(FRAME_DIVIDE - 1);
   localparam logic [3:0]        BYTE_LAST = 4'(NUM_BYTES - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [3:0]        byte_q, byte_d;
   logic              tx_q, tx_d;
   logic              done_q, done_d;

   logic [DIV_W-1:0]  div_q;
   logic [7:0]        drop_q;

   logic [15:0]       snap_x, snap_y, snap_spd, snap_dir, snap_cam;
   logic [7:0]        snap_score;
   logic [2:0]        snap_state;

   logic              eligible, start_pkt, drop_pkt, bit_end;
   logic [2:0]        bit_nx;
   logic [7:0]        cur_byte;

   assign eligible  = tel.new_frame && (div_q == DIV_LAST);
   assign start_pkt = eligible && tel.enable_in && (state_q == IDLE);
   assign drop_pkt  = eligible && tel.enable_in && (state_q != IDLE);
   assign bit_end   = (baud_q == BAUD_LAST);
   assign bit_nx    = bit_q + 3'd1;

`ifdef TELEMETRY_CHECKSUM_EN
   logic [7:0] checksum;
   assign checksum = snap_x[15:8] ^ snap_x[7:0] ^ snap_y[15:8] ^ snap_y[7:0]
                   ^ snap_spd[15:8] ^ snap_spd[7:0] ^ snap_dir[15:8] ^ snap_dir[7:0]
                   ^ snap_cam[15:8] ^ snap_cam[7:0] ^ snap_score ^ {5'b0, snap_state};
`endif

   always_comb begin
      cur_byte = '0;
      case (byte_q)
         4'd0:    cur_byte = SYNC_BYTE;
         4'd1:    cur_byte = snap_x[15:8];
         4'd2:    cur_byte = snap_x[7:0];
         4'd3:    cur_byte = snap_y[15:8];
         4'd4:    cur_byte = snap_y[7:0];
         4'd5:    cur_byte = snap_spd[15:8];
         4'd6:    cur_byte = snap_spd[7:0];
         4'd7:    cur_byte = snap_dir[15:8];
         4'd8:    cur_byte = snap_dir[7:0];
         4'd9:    cur_byte = snap_cam[15:8];
         4'd10:   cur_byte = snap_cam[7:0];
         4'd11:   cur_byte = snap_score;
         4'd12:   cur_byte = {5'b0, snap_state};
`ifdef TELEMETRY_CHECKSUM_EN
         4'd13:   cur_byte = checksum;
`endif
         default: cur_byte = '0;
      endcase
   end

   // tx is registered and loaded with the level of the bit that begins on the same edge,
   // so the start bit appears on the capture edge and stop->start has no idle gap.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (start_pkt) begin
               state_d = START;
               tx_d    = 1'b0;
               baud_d  = '0;
               bit_d   = '0;
               byte_d  = '0;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               bit_d   = '0;
               tx_d    = cur_byte[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_nx;
                  tx_d  = cur_byte[bit_nx];
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               if (byte_q == BYTE_LAST) begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  state_d = START;
                  byte_d  = byte_q + 4'd1;
                  tx_d    = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in_n) begin
         div_q      <= '0;
         drop_q     <= '0;
         snap_x     <= '0;
         snap_y     <= '0;
         snap_spd   <= '0;
         snap_dir   <= '0;
         snap_cam   <= '0;
         snap_score <= '0;
         snap_state <= '0;
      end else begin
         if (tel.new_frame) div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
         if (drop_pkt && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
         if (start_pkt) begin
            snap_x     <= tel.ball_position_x;
            snap_y     <= tel.ball_position_y;
            snap_spd   <= tel.ball_speed;
            snap_dir   <= tel.ball_direction;
            snap_cam   <= tel.cam_angle;
            snap_score <= tel.score;
            snap_state <= tel.state_in;
         end
      end
   end

   assign tel.tx_out        = tx_q;
   assign tel.busy_out      = (state_q != IDLE);
   assign tel.packet_done   = done_q;
   assign tel.dropped_count = drop_q;

endmodule
